serial_deserializer: RTL

Serial-to-parallel receiver: samples one bit per enabled clock, assembles a WIDTH-bit word and presents it on a parallel output under a valid/ready handshake. It is the receiving end of the team's load/shift register datapath: a parallel-load shifter serializes a word, and this block reconstructs it. It also provides bit counting, a sticky overrun flag and a synchronous clear.

---
 rtl/serial_deserializer.sv | 80 ++++++++
 1 files changed

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: collects WIDTH bits on enabled cycles and holds the word under valid/ready.
// A word that completes while the held word is still unconsumed is dropped and flagged by a sticky overrun.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     serial_in,
  input  logic                     shift_en,
  input  logic                     clear,
  input  logic                     data_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // state | meaning
  // EMPTY | no word held, data_valid=0
  // FULL  | word held in data_out, data_valid=1
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] sreg, sreg_shifted;
  logic             shift, complete, load_out, set_overrun;

  // A clear in the same cycle discards the incoming bit.
  assign shift    = shift_en && !clear;
  assign complete = shift && (bit_count == LAST_BIT);

  if (MSB_FIRST) begin : g_msb_first
    assign sreg_shifted = {sreg[WIDTH-2:0], serial_in};
  end else begin : g_lsb_first
    assign sreg_shifted = {serial_in, sreg[WIDTH-1:1]};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (complete) state_next = FULL;
        FULL:    if (data_ready && !complete) state_next = EMPTY;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    data_valid  = (state == FULL);
    load_out    = complete && ((state == EMPTY) || data_ready);
    set_overrun = complete && (state == FULL) && !data_ready;
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      sreg      <= '0;
      bit_count <= '0;
      data_out  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (shift) begin
        sreg      <= sreg_shifted;
        bit_count <= complete ? '0 : bit_count + CW'(1);
      end
      if (load_out)    data_out <= sreg_shifted;
      if (set_overrun) overrun  <= 1'b1;
    end
  end

endmodule
